// File: rtl/chaos_pkg.sv
// chaos_pkg: level encodings and saturating score arithmetic for the chaos monitor
package chaos_pkg;
  localparam int SAT_W = 32;
  typedef enum logic [1:0] {
    CHAOS_CALM = 2'd0,
    CHAOS_WARN = 2'd1,
    CHAOS_CRIT = 2'd2
  } chaos_level_t;
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] max);
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s > {1'b0, max} ? max : s[SAT_W-1:0];
  endfunction
  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a, input logic [SAT_W-1:0] b);
    return a > b ? a - b : '0;
  endfunction
endpackage

// File: rtl/chaos_event_accum.sv
// chaos_event_accum: masked per-source weight sum and popcount of asserted event strobes
module chaos_event_accum #(
  parameter int NUM_SRC  = 4,
  parameter int WEIGHT_W = 12,
  parameter int SUM_W    = WEIGHT_W + $clog2(NUM_SRC),
  parameter int CNT_W    = $clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC-1:0]          event_valid,
  input  logic [NUM_SRC*WEIGHT_W-1:0] event_weight,
  output logic [SUM_W-1:0]            sum,
  output logic [CNT_W-1:0]            cnt
);
  always_comb begin
    sum = '0;
    cnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sum = sum + (event_valid[i] ? SUM_W'(event_weight[i*WEIGHT_W +: WEIGHT_W]) : '0);
      cnt = cnt + CNT_W'(event_valid[i]);
    end
  end
endmodule

// File: rtl/chaos_monitor_mc.sv
// chaos_monitor_mc: multi-source weighted chaos score with interval decay and hysteretic level
module chaos_monitor_mc
  import chaos_pkg::*;
#(
  parameter int                 NUM_SRC        = 4,
  parameter int                 SCORE_W        = 16,
  parameter int                 WEIGHT_W       = 12,
  parameter int                 DECAY_INTERVAL = 16,
  parameter int                 DECAY_STEP     = 1,
  parameter logic [SCORE_W-1:0] WARN_TH        = 16'h0400,
  parameter logic [SCORE_W-1:0] CRIT_TH        = 16'h0800,
  parameter logic [SCORE_W-1:0] HYST           = 16'h0100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        clear,
  input  logic [NUM_SRC-1:0]          event_valid,
  input  logic [NUM_SRC*WEIGHT_W-1:0] event_weight,
  output logic [SCORE_W-1:0]          chaos_score_out,
  output logic [1:0]                  chaos_level,
  output logic                        crit_pulse,
  output logic [15:0]                 event_count
);
  localparam int SUM_W = WEIGHT_W + $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(NUM_SRC + 1);
  localparam int DC_W  = DECAY_INTERVAL > 1 ? $clog2(DECAY_INTERVAL) : 1;
  localparam logic [SCORE_W-1:0] WARN_EXIT = WARN_TH - HYST;
  localparam logic [SCORE_W-1:0] CRIT_EXIT = CRIT_TH - HYST;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [DC_W-1:0]    DC_LAST   = DC_W'(DECAY_INTERVAL - 1);
  logic [SUM_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt;
  logic [DC_W-1:0]    dcnt;
  logic               decay_tick;
  logic [SCORE_W-1:0] score, score_nx;
  logic [16:0]        count_sum;
  chaos_level_t       level;
  chaos_event_accum #(.NUM_SRC(NUM_SRC), .WEIGHT_W(WEIGHT_W), .SUM_W(SUM_W), .CNT_W(CNT_W)) u_accum (
    .event_valid (event_valid),
    .event_weight(event_weight),
    .sum         (sum),
    .cnt         (cnt)
  );
  assign decay_tick = dcnt == DC_LAST;
  assign count_sum  = {1'b0, event_count} + 17'(cnt);
  // any incoming weight suppresses the decay tick for that cycle
  assign score_nx = sum != '0 ? SCORE_W'(sat_add(SAT_W'(score), SAT_W'(sum), SAT_W'(SCORE_MAX)))
                  : decay_tick ? SCORE_W'(sat_sub(SAT_W'(score), SAT_W'(DECAY_STEP)))
                  : score;
  assign chaos_score_out = score;
  assign chaos_level     = level;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score       <= '0;
      level       <= CHAOS_CALM;
      crit_pulse  <= 1'b0;
      event_count <= '0;
      dcnt        <= '0;
    end else if (!enable) begin
      crit_pulse <= 1'b0;
    end else begin
      score       <= score_nx;
      dcnt        <= decay_tick ? '0 : dcnt + 1'b1;
      event_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
      crit_pulse  <= (level == CHAOS_CALM || level == CHAOS_WARN) && score >= CRIT_TH;
      case (level)
        CHAOS_CALM: level <= score >= CRIT_TH ? CHAOS_CRIT : score >= WARN_TH ? CHAOS_WARN : CHAOS_CALM;
        CHAOS_WARN: level <= score >= CRIT_TH ? CHAOS_CRIT : score < WARN_EXIT ? CHAOS_CALM : CHAOS_WARN;
        CHAOS_CRIT: level <= score >= CRIT_EXIT ? CHAOS_CRIT : score < WARN_EXIT ? CHAOS_CALM : CHAOS_WARN;
        default:    level <= CHAOS_CALM;
      endcase
    end
  end
endmodule

// File: tb/tb_chaos_monitor_mc.sv
// tb_chaos_monitor_mc: randomized and directed scoreboard bench for chaos_monitor_mc
module tb_chaos_monitor_mc;
  localparam int DI      = 16;
  localparam int WARN_TH = 'h400;
  localparam int CRIT_TH = 'h800;
  localparam int HYST    = 'h100;
  logic        clk = 1'b0;
  logic        reset = 1'b1, enable = 1'b0, clear = 1'b0;
  logic [3:0]  event_valid = '0;
  logic [47:0] event_weight = '0;
  logic [15:0] chaos_score_out, event_count;
  logic [1:0]  chaos_level;
  logic        crit_pulse;
  always #5 clk = ~clk;
  chaos_monitor_mc dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .clear          (clear),
    .event_valid    (event_valid),
    .event_weight   (event_weight),
    .chaos_score_out(chaos_score_out),
    .chaos_level    (chaos_level),
    .crit_pulse     (crit_pulse),
    .event_count    (event_count)
  );
  typedef struct {
    logic [15:0] s;
    logic [1:0]  l;
    logic        p;
    logic [15:0] c;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, pulses = 0;
  int m_score = 0, m_level = 0, m_pulse = 0, m_count = 0, m_phase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int classify(input int lvl, input int s);
    if (lvl == 0) return s >= CRIT_TH ? 2 : s >= WARN_TH ? 1 : 0;
    if (lvl == 1) return s >= CRIT_TH ? 2 : s < WARN_TH - HYST ? 0 : 1;
    if (lvl == 2) return s < CRIT_TH - HYST ? (s < WARN_TH - HYST ? 0 : 1) : 2;
    return 0;
  endfunction

  task automatic drive(input bit rst, input bit clr, input bit en, input logic [3:0] v, input logic [47:0] w);
    int sum, pop, nl;
    bit tick;
    exp_t e;
    @(negedge clk);
    reset = rst; clear = clr; enable = en; event_valid = v; event_weight = w;
    if (rst || clr) begin
      m_score = 0; m_level = 0; m_pulse = 0; m_count = 0; m_phase = 0;
    end else if (!en) begin
      m_pulse = 0;
    end else begin
      sum = 0; pop = 0;
      for (int i = 0; i < 4; i++) if (v[i]) begin sum += int'(w[i*12 +: 12]); pop++; end
      tick = m_phase == DI - 1;
      m_phase = (m_phase + 1) % DI;
      nl = classify(m_level, m_score);
      m_pulse = (nl == 2 && m_level != 2) ? 1 : 0;
      m_level = nl;
      m_score = sum != 0 ? (m_score + sum > 65535 ? 65535 : m_score + sum)
              : tick ? (m_score > 1 ? m_score - 1 : 0) : m_score;
      m_count = m_count + pop > 65535 ? 65535 : m_count + pop;
    end
    e.s = 16'(m_score); e.l = 2'(m_level); e.p = 1'(m_pulse); e.c = 16'(m_count);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 4'h0, 48'h0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("score", chaos_score_out, e.s);
        chk("level", chaos_level, e.l);
        chk("crit_pulse", crit_pulse, e.p);
        chk("event_count", event_count, e.c);
        if (crit_pulse === 1'b1) pulses++;
      end
    end
  end

  initial begin
    int p0, n;
    logic [3:0] v;
    logic [47:0] w;
    drive(1, 0, 1, 4'hF, 48'hFFF_FFF_FFF_FFF);
    drive(1, 0, 1, 4'hF, 48'hFFF_FFF_FFF_FFF);
    idle(1);
    chk("reset_score", chaos_score_out, 0);
    chk("reset_level", chaos_level, 0);
    chk("reset_count", event_count, 0);
    chk("reset_pulse", crit_pulse, 0);
    drive(0, 0, 1, 4'b0001, 48'h000_000_000_100);
    idle(1);
    chk("single_score", chaos_score_out, 'h100);
    chk("single_count", event_count, 1);
    drive(0, 0, 1, 4'b0011, 48'h000_000_050_100);
    idle(1);
    chk("dual_score", chaos_score_out, 'h250);
    chk("dual_count", event_count, 3);
    drive(0, 1, 1, 4'h0, 48'h0);
    p0 = pulses;
    for (int i = 0; i < 20; i++) drive(0, 0, 1, 4'hF, 48'hFFF_FFF_FFF_FFF);
    idle(3);
    chk("sat_score", chaos_score_out, 'hFFFF);
    chk("sat_level", chaos_level, 2);
    chk("sat_pulses", pulses - p0, 1);
    drive(0, 1, 1, 4'h0, 48'h0);
    drive(0, 0, 1, 4'b0001, 48'h3);
    idle(48);
    chk("decay_to_zero", chaos_score_out, 0);
    idle(20);
    chk("decay_hold_zero", chaos_score_out, 0);
    drive(0, 1, 1, 4'h0, 48'h0);
    drive(0, 0, 1, 4'b0001, 48'hA);
    idle(14);
    drive(0, 0, 1, 4'b0100, 48'h000_001_000_000);
    idle(1);
    chk("tick_suppressed", chaos_score_out, 'hB);
    drive(0, 1, 1, 4'h0, 48'h0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 4'b0001, 48'h100);
    idle(3);
    chk("ramp_crit", chaos_level, 2);
    n = 0;
    while (m_score > 'h750 && n < 30000) begin idle(1); n++; end
    idle(2);
    chk("crit_hold_0750", chaos_level, 2);
    while (m_score >= 'h700 && n < 30000) begin idle(1); n++; end
    idle(3);
    chk("crit_to_warn", chaos_level, 1);
    while (m_score >= 'h300 && n < 30000) begin idle(1); n++; end
    idle(3);
    chk("warn_to_calm", chaos_level, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 4'b0001, 48'h100);
    drive(0, 1, 1, 4'hF, 48'hFFF_FFF_FFF_FFF);
    idle(1);
    chk("clear_score", chaos_score_out, 0);
    chk("clear_level", chaos_level, 0);
    chk("clear_count", event_count, 0);
    for (int i = 0; i < 600; i++) begin
      v = 4'($urandom);
      for (int j = 0; j < 4; j++) w[j*12 +: 12] = ($urandom_range(0, 15) == 0) ? 12'($urandom) : 12'($urandom_range(0, 'h60));
      drive(0, $urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, ($urandom_range(0, 2) == 0) ? 4'h0 : v, w);
    end
    idle(4);
    n = 0;
    while (q.size() != 0 && n < 10) begin @(negedge clk); n++; end
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
